fifo_uart_tx: RTL and testbench

Downstream drain stage for the synchronous FIFO. It pops one word at a time through the FIFO's rd_en/empty/dout interface and serialises each word onto a UART-style line: start bit, data LSB-first, optional parity, then stop bit(s). It sits between the FIFO read port and the chip-level serial pin, and it reports busy and frame-complete status to control logic.

---
 rtl/fifo_uart_tx.sv | 118 +++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time from a synchronous FIFO and
// serialises it as start bit, LSB-first data, optional parity and stop bit(s).
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [BW-1:0]    baud;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_d;
    logic             parity_bit;
    logic             tx_d;
    logic             bit_tick;

    assign bit_tick = (baud == BAUD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tx_en && !fifo_empty) next_state = POP;
            POP:     next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (bit_tick) next_state = DATA;
            DATA:    if (bit_tick && bit_idx == DATA_LAST)
                         next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_tick) next_state = STOP;
            STOP:    if (bit_tick && bit_idx == STOP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shift-register and line value as they will be after this edge, so tx
    // changes on the very edge that enters the state defining it.
    always_comb begin
        shreg_d = shreg;
        if (state == LOAD)
            shreg_d = fifo_dout;
        else if (state == DATA && bit_tick)
            shreg_d = shreg >> 1;

        tx_d = 1'b1;
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            if (state inside {IDLE, POP, LOAD} || bit_tick) baud <= '0;
            else                                            baud <= baud + BW'(1);

            // Index restarts on entry to DATA and is reused to count stop bits.
            if (next_state != state) bit_idx <= '0;
            else if (bit_tick)       bit_idx <= bit_idx + IW'(1);

            shreg <= shreg_d;
            if (state == LOAD) parity_bit <= (^fifo_dout) ^ (PARITY_ODD != 0);
            tx <= tx_d;
        end
    end

    always_comb begin
        fifo_rd_en = (state == POP);
        busy       = (state != IDLE);
        frame_done = (state == STOP) && bit_tick && (bit_idx == STOP_LAST);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances (plain, even parity, odd
// parity, two stop bits) each fed by a small behavioural FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en [4] = '{default: 1'b0};
    logic       empty [4];
    logic [7:0] dout  [4] = '{default: 8'h00};
    logic       rd    [4];
    logic       tx    [4];
    logic       busy  [4];
    logic       done  [4];

    logic [7:0] mem [4][16];
    int         wr_cnt    [4] = '{default: 0};
    int         rd_ptr    [4] = '{default: 0};
    int         rd_seen   [4] = '{default: 0};
    int         done_seen [4] = '{default: 0};
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, valid the cycle after the pop.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd[i] === 1'b1) begin
                dout[i]   <= mem[i][rd_ptr[i][3:0]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) empty[i] = (wr_cnt[i] == rd_ptr[i]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd[i] === 1'b1)   rd_seen[i]   <= rd_seen[i] + 1;
            if (done[i] === 1'b1) done_seen[i] <= done_seen[i] + 1;
        end
    end

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst_n), .tx_en(tx_en[0]), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
        .fifo_rd_en(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst_n), .tx_en(tx_en[1]), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
        .fifo_rd_en(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst_n), .tx_en(tx_en[2]), .fifo_empty(empty[2]), .fifo_dout(dout[2]),
        .fifo_rd_en(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst_n), .tx_en(tx_en[3]), .fifo_empty(empty[3]), .fifo_dout(dout[3]),
        .fifo_rd_en(rd[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(done[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] v);
        mem[i][wr_cnt[i][3:0]] = v;
        wr_cnt[i]++;
    endtask

    // Returns at the negedge of the first START cycle; t is its cycle number.
    task automatic wait_fall(input int i, input int budget, output int t);
        logic found;
        found = 1'b0;
        t = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx[i] === 1'b0) begin
                found = 1'b1;
                t = cyc;
                break;
            end
        end
        check($sformatf("start_seen u%0d", i), 32'(found), 32'd1);
    endtask

    // Called at offset 0 (first START cycle); returns at offset L (first cycle after frame).
    task automatic check_frame(input string tag, input int i, input logic [7:0] word,
                               input int pen, input logic pbit, input int sbits);
        int   nb;
        int   len;
        int   ndone;
        int   dpos;
        logic exp_bit;
        nb    = 1 + 8 + pen + sbits;
        len   = nb * CPB;
        ndone = 0;
        dpos  = -1;
        for (int off = 1; off <= len; off++) begin
            @(negedge clk);
            if (off < len && (off % CPB) == CPB / 2) begin
                int b;
                b = off / CPB;
                if (b == 0)                  exp_bit = 1'b0;
                else if (b <= 8)             exp_bit = word[b-1];
                else if (pen != 0 && b == 9) exp_bit = pbit;
                else                         exp_bit = 1'b1;
                check($sformatf("%s bit%0d", tag, b), 32'(tx[i]), 32'(exp_bit));
            end
            if (off < len && done[i] === 1'b1) begin
                ndone++;
                dpos = off;
            end
            if (off == len - 1) check({tag, " busy_last"}, 32'(busy[i]), 32'd1);
            if (off == len) begin
                check({tag, " busy_after"}, 32'(busy[i]), 32'd0);
                check({tag, " done_after"}, 32'(done[i]), 32'd0);
                check({tag, " tx_after"},   32'(tx[i]),   32'd1);
            end
        end
        check({tag, " done_count"}, 32'(ndone), 32'd1);
        check({tag, " done_pos"},   32'(dpos),  32'(len - 1));
    endtask

    initial begin
        int t0, t1, r0, d0;
        logic saw_rd, saw_busy, saw_low;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst tx",   32'(tx[0]),   32'd1);
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst rd",   32'(rd[0]),   32'd0);
        check("rst done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame 0xA5
        r0 = rd_seen[0];
        push(0, 8'hA5);
        tx_en[0] = 1'b1;
        wait_fall(0, 20, t0);
        check_frame("t1", 0, 8'hA5, 0, 1'b0, 1);
        check("t1 rd_pulses", 32'(rd_seen[0] - r0), 32'd1);
        tx_en[0] = 1'b0;
        repeat (4) @(negedge clk);

        // 2: parity on 0x07, even then odd
        push(1, 8'h07);
        tx_en[1] = 1'b1;
        wait_fall(1, 20, t0);
        check_frame("t2even", 1, 8'h07, 1, 1'b1, 1);
        tx_en[1] = 1'b0;
        push(2, 8'h07);
        tx_en[2] = 1'b1;
        wait_fall(2, 20, t0);
        check_frame("t2odd", 2, 8'h07, 1, 1'b0, 1);
        tx_en[2] = 1'b0;

        // 3: back-to-back words
        r0 = rd_seen[0];
        d0 = done_seen[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        tx_en[0] = 1'b1;
        wait_fall(0, 20, t0);
        check_frame("t3w0", 0, 8'h11, 0, 1'b0, 1);
        wait_fall(0, 20, t1);
        check("t3 gap01", 32'(t1 - t0), 32'd43);
        check_frame("t3w1", 0, 8'h22, 0, 1'b0, 1);
        t0 = t1;
        wait_fall(0, 20, t1);
        check("t3 gap12", 32'(t1 - t0), 32'd43);
        check_frame("t3w2", 0, 8'h33, 0, 1'b0, 1);
        repeat (10) @(negedge clk);
        check("t3 rd_pulses",   32'(rd_seen[0] - r0),   32'd3);
        check("t3 done_pulses", 32'(done_seen[0] - d0), 32'd3);
        check("t3 idle busy",   32'(busy[0]), 32'd0);
        check("t3 idle tx",     32'(tx[0]),   32'd1);

        // 4a: disabled with a non-empty FIFO
        tx_en[0] = 1'b0;
        push(0, 8'h5A);
        push(0, 8'h66);
        saw_rd = 1'b0;
        saw_busy = 1'b0;
        saw_low = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rd[0] !== 1'b0)   saw_rd = 1'b1;
            if (busy[0] !== 1'b0) saw_busy = 1'b1;
            if (tx[0] !== 1'b1)   saw_low = 1'b1;
        end
        check("t4 gated rd",   32'(saw_rd),   32'd0);
        check("t4 gated busy", 32'(saw_busy), 32'd0);
        check("t4 gated tx",   32'(saw_low),  32'd0);

        // 4b: drop tx_en during DATA; frame completes, no further pop
        r0 = rd_seen[0];
        d0 = done_seen[0];
        tx_en[0] = 1'b1;
        wait_fall(0, 20, t0);
        repeat (14) @(negedge clk);
        check("t4 in_frame busy", 32'(busy[0]), 32'd1);
        tx_en[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("t4 done_pulses", 32'(done_seen[0] - d0), 32'd1);
        repeat (60) @(negedge clk);
        check("t4 rd_pulses", 32'(rd_seen[0] - r0), 32'd1);
        check("t4 end busy",  32'(busy[0]), 32'd0);
        check("t4 end tx",    32'(tx[0]),   32'd1);

        // 6: two stop bits on 0xFF
        push(3, 8'hFF);
        tx_en[3] = 1'b1;
        wait_fall(3, 20, t0);
        check_frame("t6", 3, 8'hFF, 0, 1'b0, 2);
        tx_en[3] = 1'b0;

        // 5: asynchronous reset during data bit 3 of 0x66 (bit value 0)
        r0 = rd_seen[0];
        tx_en[0] = 1'b1;
        wait_fall(0, 20, t0);
        repeat (17) @(negedge clk);
        check("t5 pre tx",   32'(tx[0]),   32'd0);
        check("t5 pre busy", 32'(busy[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5 async tx",   32'(tx[0]),   32'd1);
        check("t5 async busy", 32'(busy[0]), 32'd0);
        check("t5 async rd",   32'(rd[0]),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5 post busy",  32'(busy[0]), 32'd0);
        check("t5 post tx",    32'(tx[0]),   32'd1);
        check("t5 rd_pulses",  32'(rd_seen[0] - r0), 32'd1);
        tx_en[0] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
